nf10_axi_lite_master: RTL and testbench

- AXI4-Lite initiator that drives the S_AXI register port of any nf10 pipeline module (e.g. output port lookup at 32'h75400000).
- Accepts one register command at a time (read or write) on a simple valid/ready command port.
- Runs the AXI4-Lite transaction and returns data and response on a valid/ready response port.
- Has a per-transaction timeout so that a non-responding slave cannot hang the host-side sequencer.

---
 rtl/nf10_axi_lite_pkg.sv | 18 +
 rtl/nf10_axi_lite_master_if.sv | 57 +++++
 rtl/nf10_timeout_counter.sv | 36 +++
 rtl/nf10_axi_lite_master.sv | 209 ++++++++++++++++++++
 tb/tb_nf10_axi_lite_master.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nf10_axi_lite_pkg.sv
// Shared FSM state type and AXI response codes for the nf10 AXI4-Lite master.
package nf10_axi_lite_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      WR_B,
      RD_A,
      RD_R,
      RESP
   } state_e;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] EXOKAY = 2'b01;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/nf10_axi_lite_master_if.sv
// Host command/response port plus the AXI4-Lite master bus, bundled for the nf10 register initiator.
interface nf10_axi_lite_master_if #(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32
);
   localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

   logic                          cmd_valid;
   logic                          cmd_ready;
   logic                          cmd_rnw;
   logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr;
   logic [C_M_AXI_DATA_WIDTH-1:0] cmd_wdata;
   logic [STRB_W-1:0]             cmd_wstrb;

   logic                          rsp_valid;
   logic                          rsp_ready;
   logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata;
   logic [1:0]                    rsp_resp;
   logic                          rsp_timeout;

   logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR;
   logic                          M_AXI_AWVALID;
   logic                          M_AXI_AWREADY;
   logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA;
   logic [STRB_W-1:0]             M_AXI_WSTRB;
   logic                          M_AXI_WVALID;
   logic                          M_AXI_WREADY;
   logic [1:0]                    M_AXI_BRESP;
   logic                          M_AXI_BVALID;
   logic                          M_AXI_BREADY;
   logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR;
   logic                          M_AXI_ARVALID;
   logic                          M_AXI_ARREADY;
   logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA;
   logic [1:0]                    M_AXI_RRESP;
   logic                          M_AXI_RVALID;
   logic                          M_AXI_RREADY;

   modport master (
      input  cmd_valid, cmd_rnw, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
             M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
             M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
             M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
             M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY
   );

   modport slave (
      output cmd_valid, cmd_rnw, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
             M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
             M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
             M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
             M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY
   );

endinterface

// File: rtl/nf10_timeout_counter.sv
// Saturating cycle counter that flags the last cycle a bus phase may wait before being aborted.
module nf10_timeout_counter #(
   parameter int C_TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int              CNT_W = $clog2(C_TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(C_TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // High during the C_TIMEOUT_CYCLES-th waiting cycle, so the abort lands exactly at the limit.
   assign expired = (cnt_q >= (LIMIT - CNT_W'(1)));

endmodule

// File: rtl/nf10_axi_lite_master.sv
// AXI4-Lite initiator: runs one register read or write at a time and aborts phases that exceed a timeout.
module nf10_axi_lite_master
   import nf10_axi_lite_pkg::*;
#(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_TIMEOUT_CYCLES   = 1024
) (
   input  logic                   axi_aclk,
   input  logic                   axi_reset,
   nf10_axi_lite_master_if.master bus
);
   localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

   state_e                        state_q, state_d;
   logic                          aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic                          awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
   logic                          arvalid_q, arvalid_d, rready_q, rready_d;
   logic                          cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
   logic                          rsp_timeout_q, rsp_timeout_d;
   logic [1:0]                    rsp_resp_q, rsp_resp_d;
   logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d, wdata_q, wdata_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [STRB_W-1:0]             wstrb_q, wstrb_d;
   logic                          accept, aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic                          abort, tmo_enable, tmo_expired;

   assign accept     = (state_q == IDLE) && cmd_ready_q && bus.cmd_valid;
   assign aw_hs      = awvalid_q && bus.M_AXI_AWREADY;
   assign w_hs       = wvalid_q && bus.M_AXI_WREADY;
   assign b_hs       = bready_q && bus.M_AXI_BVALID;
   assign ar_hs      = arvalid_q && bus.M_AXI_ARREADY;
   assign r_hs       = rready_q && bus.M_AXI_RVALID;
   assign tmo_enable = (state_q == WR) || (state_q == WR_B) || (state_q == RD_A) || (state_q == RD_R);

   nf10_timeout_counter #(
      .C_TIMEOUT_CYCLES(C_TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (axi_aclk),
      .rst    (axi_reset),
      .clear  (accept),
      .enable (tmo_enable),
      .expired(tmo_expired)
   );

   always_comb begin
      state_d       = state_q;
      aw_done_d     = aw_done_q;
      w_done_d      = w_done_q;
      awvalid_d     = awvalid_q;
      wvalid_d      = wvalid_q;
      bready_d      = bready_q;
      arvalid_d     = arvalid_q;
      rready_d      = rready_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_timeout_d = rsp_timeout_q;
      rsp_resp_d    = rsp_resp_q;
      rsp_rdata_d   = rsp_rdata_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      wstrb_d       = wstrb_q;
      abort         = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               addr_d        = bus.cmd_addr;
               wdata_d       = bus.cmd_wdata;
               wstrb_d       = bus.cmd_wstrb;
               rsp_timeout_d = 1'b0;
               aw_done_d     = 1'b0;
               w_done_d      = 1'b0;
               if (bus.cmd_rnw) begin
                  state_d   = RD_A;
                  arvalid_d = 1'b1;
               end else begin
                  state_d   = WR;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end
            end
         end
         WR: begin
            if (aw_hs) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (w_hs) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            // Completion is checked before the timeout so a handshake on the limit cycle still succeeds.
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
               state_d  = WR_B;
               bready_d = 1'b1;
            end else if (tmo_expired) begin
               abort = 1'b1;
            end
         end
         WR_B: begin
            if (b_hs) begin
               state_d     = RESP;
               bready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_resp_d  = bus.M_AXI_BRESP;
               rsp_rdata_d = '0;
            end else if (tmo_expired) begin
               abort = 1'b1;
            end
         end
         RD_A: begin
            if (ar_hs) begin
               state_d   = RD_R;
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
            end else if (tmo_expired) begin
               abort = 1'b1;
            end
         end
         RD_R: begin
            if (r_hs) begin
               state_d     = RESP;
               rready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_resp_d  = bus.M_AXI_RRESP;
               rsp_rdata_d = bus.M_AXI_RDATA;
            end else if (tmo_expired) begin
               abort = 1'b1;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (abort) begin
         state_d       = RESP;
         awvalid_d     = 1'b0;
         wvalid_d      = 1'b0;
         bready_d      = 1'b0;
         arvalid_d     = 1'b0;
         rready_d      = 1'b0;
         rsp_valid_d   = 1'b1;
         rsp_resp_d    = SLVERR;
         rsp_timeout_d = 1'b1;
         rsp_rdata_d   = '0;
      end

      cmd_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge axi_aclk or posedge axi_reset) begin
      if (axi_reset) begin
         state_q       <= IDLE;
         aw_done_q     <= 1'b0;
         w_done_q      <= 1'b0;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         bready_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         rready_q      <= 1'b0;
         cmd_ready_q   <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_timeout_q <= 1'b0;
         rsp_resp_q    <= 2'b00;
         rsp_rdata_q   <= '0;
         addr_q        <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
      end else begin
         state_q       <= state_d;
         aw_done_q     <= aw_done_d;
         w_done_q      <= w_done_d;
         awvalid_q     <= awvalid_d;
         wvalid_q      <= wvalid_d;
         bready_q      <= bready_d;
         arvalid_q     <= arvalid_d;
         rready_q      <= rready_d;
         cmd_ready_q   <= cmd_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_timeout_q <= rsp_timeout_d;
         rsp_resp_q    <= rsp_resp_d;
         rsp_rdata_q   <= rsp_rdata_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         wstrb_q       <= wstrb_d;
      end
   end

   assign bus.cmd_ready     = cmd_ready_q;
   assign bus.rsp_valid     = rsp_valid_q;
   assign bus.rsp_rdata     = rsp_rdata_q;
   assign bus.rsp_resp      = rsp_resp_q;
   assign bus.rsp_timeout   = rsp_timeout_q;
   assign bus.M_AXI_AWADDR  = addr_q;
   assign bus.M_AXI_AWVALID = awvalid_q;
   assign bus.M_AXI_WDATA   = wdata_q;
   assign bus.M_AXI_WSTRB   = wstrb_q;
   assign bus.M_AXI_WVALID  = wvalid_q;
   assign bus.M_AXI_BREADY  = bready_q;
   assign bus.M_AXI_ARADDR  = addr_q;
   assign bus.M_AXI_ARVALID = arvalid_q;
   assign bus.M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_nf10_axi_lite_master.sv
// Directed bench for nf10_axi_lite_master against a behavioural AXI4-Lite slave with programmable ready delays.
module tb_nf10_axi_lite_master;
   import nf10_axi_lite_pkg::*;

   localparam int TMO = 16;

   logic clk;
   logic rst;

   nf10_axi_lite_master_if #(
      .C_M_AXI_ADDR_WIDTH(32),
      .C_M_AXI_DATA_WIDTH(32)
   ) bus ();

   nf10_axi_lite_master #(
      .C_M_AXI_ADDR_WIDTH(32),
      .C_M_AXI_DATA_WIDTH(32),
      .C_TIMEOUT_CYCLES  (TMO)
   ) dut (
      .axi_aclk (clk),
      .axi_reset(rst),
      .bus      (bus)
   );

   int          n_chk = 0;
   int          n_err = 0;
   int          cyc   = 0;
   int          aw_delay = 0, w_delay = 0, ar_delay = 0;
   logic        b_en = 1'b1;
   logic [1:0]  bresp_v = 2'b00, rresp_v = 2'b00;
   logic [31:0] rdata_v = 32'h0;
   int          n_aw = 0, n_w = 0, n_b = 0;
   logic [6:0]  ctrl;

   assign ctrl = {bus.cmd_ready, bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY,
                  bus.M_AXI_ARVALID, bus.M_AXI_RREADY, bus.rsp_valid};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of test, expected finish");
      $fatal(1);
   end

   // Slave model: readies after N waiting cycles, B/R answered the cycle their READY is seen.
   initial begin
      int aw_wait, w_wait, ar_wait;
      aw_wait = 0; w_wait = 0; ar_wait = 0;
      bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0; bus.M_AXI_ARREADY = 1'b0;
      bus.M_AXI_BVALID  = 1'b0; bus.M_AXI_BRESP  = 2'b00;
      bus.M_AXI_RVALID  = 1'b0; bus.M_AXI_RRESP  = 2'b00; bus.M_AXI_RDATA = 32'h0;
      forever begin
         @(negedge clk);
         if (bus.M_AXI_AWVALID) begin
            bus.M_AXI_AWREADY = (aw_wait >= aw_delay); aw_wait++;
         end else begin
            bus.M_AXI_AWREADY = 1'b0; aw_wait = 0;
         end
         if (bus.M_AXI_WVALID) begin
            bus.M_AXI_WREADY = (w_wait >= w_delay); w_wait++;
         end else begin
            bus.M_AXI_WREADY = 1'b0; w_wait = 0;
         end
         if (bus.M_AXI_ARVALID) begin
            bus.M_AXI_ARREADY = (ar_wait >= ar_delay); ar_wait++;
         end else begin
            bus.M_AXI_ARREADY = 1'b0; ar_wait = 0;
         end
         bus.M_AXI_BVALID = bus.M_AXI_BREADY && b_en;
         bus.M_AXI_BRESP  = bresp_v;
         bus.M_AXI_RVALID = bus.M_AXI_RREADY;
         bus.M_AXI_RRESP  = rresp_v;
         bus.M_AXI_RDATA  = rdata_v;
         if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) n_aw++;
         if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) n_w++;
         if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) n_b++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   // Called on a negedge; returns on the negedge one cycle after the accepting edge (cyc = 1).
   task automatic issue(input logic rnw, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output int waited);
      waited = 0;
      while (bus.cmd_ready !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      chk("cmd_ready_before_issue", bus.cmd_ready, 1'b1);
      bus.cmd_valid = 1'b1;
      bus.cmd_rnw   = rnw;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wdata;
      bus.cmd_wstrb = strb;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      cyc = 1;
   endtask

   task automatic wait_rsp(input int limit);
      while (bus.rsp_valid !== 1'b1 && cyc < limit) step();
      chk("rsp_valid_within_bound", bus.rsp_valid, 1'b1);
   endtask

   task automatic take_rsp();
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk("after_rsp_ctrl", ctrl, 7'b1000000);
   endtask

   initial begin
      int w8, na, nw, nb;
      rst = 1'b1;
      bus.cmd_valid = 1'b0; bus.cmd_rnw = 1'b0; bus.cmd_addr = 32'h0;
      bus.cmd_wdata = 32'h0; bus.cmd_wstrb = 4'h0; bus.rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_ctrl", ctrl, 7'b0000000);
      chk("reset_rsp", {bus.rsp_resp, bus.rsp_timeout, bus.rsp_rdata}, 35'h0);
      chk("reset_addr", {bus.M_AXI_AWADDR, bus.M_AXI_ARADDR}, 64'h0);
      rst = 1'b0;

      // Write, slave always ready
      issue(1'b0, 32'h7540_0010, 32'hDEAD_BEEF, 4'hF, w8);
      chk("wr_t1_ctrl", ctrl, 7'b0110000);
      chk("wr_t1_awaddr", bus.M_AXI_AWADDR, 32'h7540_0010);
      chk("wr_t1_wdata_strb", {bus.M_AXI_WDATA, bus.M_AXI_WSTRB}, {32'hDEAD_BEEF, 4'hF});
      step();
      chk("wr_t2_ctrl", ctrl, 7'b0001000);
      step();
      chk("wr_t3_ctrl", ctrl, 7'b0000001);
      chk("wr_rsp", {bus.rsp_resp, bus.rsp_timeout, bus.rsp_rdata}, {OKAY, 1'b0, 32'h0});
      take_rsp();

      // Read with ARREADY held off for 5 cycles
      ar_delay = 5; rdata_v = 32'hDEAD_BEEF; rresp_v = OKAY;
      issue(1'b1, 32'h7540_0010, 32'h0, 4'h0, w8);
      for (int i = 0; i < 5; i++) begin
         chk("rd_arvalid_hold", {bus.M_AXI_ARVALID, bus.M_AXI_ARADDR}, {1'b1, 32'h7540_0010});
         step();
      end
      wait_rsp(50);
      chk("rd_latency", cyc, 8);
      chk("rd_rsp", {bus.rsp_resp, bus.rsp_timeout, bus.rsp_rdata}, {OKAY, 1'b0, 32'hDEAD_BEEF});
      take_rsp();

      // Read that never gets ARREADY
      ar_delay = 1000;
      issue(1'b1, 32'h7540_0020, 32'h0, 4'h0, w8);
      while (cyc < TMO) step();
      chk("tmo_last_wait_ctrl", ctrl, 7'b0000100);
      step();
      chk("tmo_abort_ctrl", ctrl, 7'b0000001);
      chk("tmo_rsp", {bus.rsp_resp, bus.rsp_timeout, bus.rsp_rdata}, {SLVERR, 1'b1, 32'h0});
      take_rsp();

      // Write with W accepted 3 cycles before AW
      ar_delay = 0; aw_delay = 3; w_delay = 0; bresp_v = EXOKAY;
      na = n_aw; nw = n_w; nb = n_b;
      issue(1'b0, 32'h7540_0030, 32'h1234_5678, 4'h3, w8);
      chk("wfirst_t1_ctrl", ctrl, 7'b0110000);
      for (int i = 2; i <= 4; i++) begin
         step();
         chk("wfirst_aw_pending_ctrl", ctrl, 7'b0100000);
      end
      step();
      chk("wfirst_t5_ctrl", ctrl, 7'b0001000);
      wait_rsp(30);
      chk("wfirst_latency", cyc, 6);
      chk("wfirst_rsp", {bus.rsp_resp, bus.rsp_timeout, bus.rsp_rdata}, {EXOKAY, 1'b0, 32'h0});
      take_rsp();
      repeat (3) step();
      chk("wfirst_no_second_rsp", ctrl, 7'b1000000);
      chk("wfirst_handshakes", {8'(n_aw - na), 8'(n_w - nw), 8'(n_b - nb)}, 24'h010101);

      // AW handshake and then B handshake land on/after the timeout limit: completion wins
      aw_delay = 15; w_delay = 0; bresp_v = DECERR;
      issue(1'b0, 32'h7540_0034, 32'h0000_00AA, 4'h1, w8);
      wait_rsp(40);
      chk("tie_latency", cyc, 18);
      chk("tie_rsp", {bus.rsp_resp, bus.rsp_timeout, bus.rsp_rdata}, {DECERR, 1'b0, 32'h0});
      take_rsp();

      // Response stalled 10 cycles, then back-to-back write
      aw_delay = 0; bresp_v = OKAY; rdata_v = 32'hA5A5_0F0F; rresp_v = SLVERR;
      issue(1'b1, 32'h7540_0040, 32'h0, 4'h0, w8);
      wait_rsp(20);
      chk("stall_rd_latency", cyc, 3);
      for (int i = 0; i < 10; i++) begin
         chk("stall_hold", {ctrl, bus.rsp_resp, bus.rsp_timeout, bus.rsp_rdata},
             {7'b0000001, SLVERR, 1'b0, 32'hA5A5_0F0F});
         step();
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk("stall_release_ctrl", ctrl, 7'b1000000);
      issue(1'b0, 32'h7540_0044, 32'h5555_AAAA, 4'hC, w8);
      chk("b2b_accept_wait", w8, 0);
      wait_rsp(20);
      chk("b2b_latency", cyc, 3);
      chk("b2b_rsp", {bus.rsp_resp, bus.rsp_timeout, bus.rsp_rdata}, {OKAY, 1'b0, 32'h0});
      take_rsp();

      // Asynchronous reset while waiting in WR_B
      b_en = 1'b0;
      issue(1'b0, 32'h7540_0048, 32'h0BAD_F00D, 4'hF, w8);
      step();
      chk("wrb_ctrl", ctrl, 7'b0001000);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_ctrl", ctrl, 7'b0000000);
      chk("async_rst_addr", {bus.M_AXI_AWADDR, bus.M_AXI_WSTRB}, 36'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      b_en = 1'b1;
      repeat (3) step();
      chk("post_rst_idle_ctrl", ctrl, 7'b1000000);
      issue(1'b0, 32'h7540_0050, 32'hCAFE_F00D, 4'hF, w8);
      chk("post_rst_awaddr", {bus.M_AXI_AWADDR, bus.M_AXI_WDATA}, {32'h7540_0050, 32'hCAFE_F00D});
      wait_rsp(20);
      chk("post_rst_latency", cyc, 3);
      chk("post_rst_rsp", {bus.rsp_resp, bus.rsp_timeout, bus.rsp_rdata}, {OKAY, 1'b0, 32'h0});
      take_rsp();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
